cp0_unit: RTL and testbench

CP0_UNIT -- requirements
Module: cp0_unit

---
 rtl/cp0_pkg.sv | 56 +++++
 rtl/cp0_timer.sv | 50 +++++
 rtl/cp0_unit.sv | 123 ++++++++++++
 tb/tb_cp0_unit.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// cp0_pkg -- shared definitions for the coprocessor-0 slice.
// Holds CP0 register numbers, exception codes, SR/Cause field positions,
// the exception handler address and helpers that pack SR and Cause into
// their 32-bit read-back layout.
// Optional feature macro: CP0_TIMER_EN (enables Count/Compare, see cp0_timer).
package cp0_pkg;

   // CP0 register numbers as seen by mtc0/mfc0
   localparam logic [4:0] REG_COUNT   = 5'd9;
   localparam logic [4:0] REG_COMPARE = 5'd11;
   localparam logic [4:0] REG_SR      = 5'd12;
   localparam logic [4:0] REG_CAUSE   = 5'd13;
   localparam logic [4:0] REG_EPC     = 5'd14;
   localparam logic [4:0] REG_PRID    = 5'd15;

   // Exception codes written into Cause.ExcCode
   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;

   // Field positions inside SR and Cause
   localparam int SR_IE        = 0;
   localparam int SR_EXL       = 1;
   localparam int SR_IM_LO     = 10;
   localparam int CAUSE_EXC_LO = 2;
   localparam int CAUSE_IP_LO  = 10;
   localparam int CAUSE_BD     = 31;

   // Where the PC goes when req is raised
   localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

   // SR as read by mfc0; unimplemented bits read as zero
   function automatic logic [31:0] pack_sr(input logic [5:0] im, input logic exl,
                                           input logic ie);
      logic [31:0] w;
      w = '0;
      w[SR_IM_LO +: 6] = im;
      w[SR_EXL]        = exl;
      w[SR_IE]         = ie;
      return w;
   endfunction

   // Cause as read by mfc0; unimplemented bits read as zero
   function automatic logic [31:0] pack_cause(input logic bd, input logic [5:0] ip,
                                              input logic [4:0] exc_code);
      logic [31:0] w;
      w = '0;
      w[CAUSE_BD]             = bd;
      w[CAUSE_IP_LO +: 6]     = ip;
      w[CAUSE_EXC_LO +: 5]    = exc_code;
      return w;
   endfunction

endpackage

// File: rtl/cp0_timer.sv
// cp0_timer -- Count/Compare timer for CP0 (only built with CP0_TIMER_EN).
// Ports:
//   clk, reset        clock and asynchronous active-high reset
//   wr_en             mtc0 write that is allowed to commit this cycle
//   addr, wdata       mtc0 register number and data
//   count, compare    current register values (for mfc0)
//   timer_pend        sticky timer interrupt request, cleared by a Compare write
module cp0_timer
   import cp0_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        wr_en,
   input  logic [4:0]  addr,
   input  logic [31:0] wdata,
   output logic [31:0] count,
   output logic [31:0] compare,
   output logic        timer_pend
);

   logic [31:0] count_next;

   // Count free-runs and wraps naturally; an mtc0 to Count replaces the
   // increment for that cycle.
   always_comb begin
      count_next = count + 32'd1;
      if (wr_en && addr == REG_COUNT) begin
         count_next = wdata;
      end
   end

   // The match is taken against the value Count is about to hold, so the
   // pending bit rises on the same edge that Count reaches Compare.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count      <= '0;
         compare    <= '0;
         timer_pend <= 1'b0;
      end else begin
         count <= count_next;
         if (wr_en && addr == REG_COMPARE) begin
            compare    <= wdata;
            timer_pend <= 1'b0;
         end else if (compare != 32'd0 && count_next == compare) begin
            timer_pend <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/cp0_unit.sv
// cp0_unit -- MIPS-style coprocessor 0: SR, Cause, EPC, PRId and an
// optional Count/Compare timer (define CP0_TIMER_EN to build it).
// Ports:
//   clk, reset        clock and asynchronous active-high reset
//   exc_m             M-stage exception {valid, ExcCode}
//   pc_m, bd_m        PC of the M-stage instruction and its delay-slot flag
//   hwint             level-sensitive external interrupt lines
//   we, addr, wdata   mtc0 write port
//   eret_m            eret in M, leaves the handler
//   rdata             mfc0 read data, combinational on addr
//   epc_out           current EPC
//   req               take an exception/interrupt now (flush + jump to handler)
module cp0_unit
   import cp0_pkg::*;
#(
   parameter logic [31:0] PRID_VALUE = 32'h4255_4141
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  exc_m,
   input  logic [31:0] pc_m,
   input  logic        bd_m,
   input  logic [5:0]  hwint,
   input  logic        we,
   input  logic [4:0]  addr,
   input  logic [31:0] wdata,
   input  logic        eret_m,
   output logic [31:0] rdata,
   output logic [31:0] epc_out,
   output logic        req
);

   logic [5:0]  im;
   logic        exl;
   logic        ie;
   logic        bd;
   logic [5:0]  ip;
   logic [4:0]  exc_code;
   logic [31:0] epc;
   logic [5:0]  ip_eff;
   logic        timer_pend;
   logic        int_req;
   logic        exc_req;

`ifdef CP0_TIMER_EN
   logic [31:0] count;
   logic [31:0] compare;

   // Timer writes obey the same rule as the other registers: a request
   // in the same cycle drops the write.
   cp0_timer u_timer (
      .clk        (clk),
      .reset      (reset),
      .wr_en      (we & ~req),
      .addr       (addr),
      .wdata      (wdata),
      .count      (count),
      .compare    (compare),
      .timer_pend (timer_pend)
   );
`else
   assign timer_pend = 1'b0;
`endif

   // The timer shares interrupt line 5 with the external pin.
   assign ip_eff  = {hwint[5] | timer_pend, hwint[4:0]};
   assign int_req = (|(ip_eff & im)) & ie & ~exl;
   assign exc_req = exc_m[5] & ~exl;
   // Gated by reset so nothing escapes while exc_m is still valid in reset.
   assign req     = (int_req | exc_req) & ~reset;
   assign epc_out = epc;

   // Exception entry has priority over mtc0 and eret; otherwise eret clears
   // EXL and mtc0 updates SR/EPC. IP tracks the pending lines every edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         im       <= '0;
         exl      <= 1'b0;
         ie       <= 1'b0;
         bd       <= 1'b0;
         ip       <= '0;
         exc_code <= '0;
         epc      <= '0;
      end else begin
         ip <= ip_eff;
         if (req) begin
            exl      <= 1'b1;
            bd       <= bd_m;
            epc      <= bd_m ? (pc_m - 32'd4) : pc_m;
            exc_code <= int_req ? EXC_INT : exc_m[4:0];
         end else begin
            if (eret_m) begin
               exl <= 1'b0;
            end
            if (we && addr == REG_SR) begin
               im  <= wdata[SR_IM_LO +: 6];
               exl <= wdata[SR_EXL];
               ie  <= wdata[SR_IE];
            end
            if (we && addr == REG_EPC) begin
               epc <= wdata;
            end
         end
      end
   end

   // mfc0 read mux; unimplemented registers read as zero
   always_comb begin
      rdata = '0;
      case (addr)
         REG_SR:      rdata = pack_sr(im, exl, ie);
         REG_CAUSE:   rdata = pack_cause(bd, ip, exc_code);
         REG_EPC:     rdata = epc;
         REG_PRID:    rdata = PRID_VALUE;
`ifdef CP0_TIMER_EN
         REG_COUNT:   rdata = count;
         REG_COMPARE: rdata = compare;
`endif
         default:     rdata = '0;
      endcase
   end

endmodule

// File: tb/tb_cp0_unit.sv
// tb_cp0_unit -- directed self-checking bench for cp0_unit.
// Inputs change 1 ns after a rising edge; outputs are sampled before the
// next edge. Timer scenarios follow CP0_TIMER_EN.
module tb_cp0_unit;
   import cp0_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [5:0]  exc_m = '0;
   logic [31:0] pc_m = '0;
   logic        bd_m = 1'b0;
   logic [5:0]  hwint = '0;
   logic        we = 1'b0;
   logic [4:0]  addr = '0;
   logic [31:0] wdata = '0;
   logic        eret_m = 1'b0;
   logic [31:0] rdata;
   logic [31:0] epc_out;
   logic        req;

   int total  = 0;
   int passed = 0;
   logic [31:0] v;

   cp0_unit dut (
      .clk     (clk),
      .reset   (reset),
      .exc_m   (exc_m),
      .pc_m    (pc_m),
      .bd_m    (bd_m),
      .hwint   (hwint),
      .we      (we),
      .addr    (addr),
      .wdata   (wdata),
      .eret_m  (eret_m),
      .rdata   (rdata),
      .epc_out (epc_out),
      .req     (req)
   );

   always #5 clk = ~clk;

   // Step past the next rising edge; leaves us 1 ns after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      exc_m = '0; pc_m = '0; bd_m = 1'b0; hwint = '0;
      we = 1'b0; addr = '0; wdata = '0; eret_m = 1'b0;
   endtask

   // Combinational mfc0 read
   task automatic rd(input logic [4:0] a, output logic [31:0] val);
      addr = a;
      #1;
      val = rdata;
   endtask

   task automatic apply_reset();
      idle();
      reset = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      apply_reset();
      rd(REG_SR, v);
      total++; if (v !== 32'h0) $display("[TB] FAIL reset_sr got %h expected %h", v, 32'h0); else passed++;
      rd(REG_CAUSE, v);
      total++; if (v !== 32'h0) $display("[TB] FAIL reset_cause got %h expected %h", v, 32'h0); else passed++;
      total++; if (epc_out !== 32'h0) $display("[TB] FAIL reset_epc got %h expected %h", epc_out, 32'h0); else passed++;
      rd(REG_PRID, v);
      total++; if (v !== 32'h4255_4141) $display("[TB] FAIL prid got %h expected %h", v, 32'h4255_4141); else passed++;
      rd(5'd3, v);
      total++; if (v !== 32'h0) $display("[TB] FAIL unmapped_read got %h expected %h", v, 32'h0); else passed++;
      total++; if (req !== 1'b0) $display("[TB] FAIL reset_req got %b expected 0", req); else passed++;
   endtask

   task automatic test_exception();
      apply_reset();
      exc_m = {1'b1, EXC_ADEL}; pc_m = 32'h3008; bd_m = 1'b0;
      #1;
      total++; if (req !== 1'b1) $display("[TB] FAIL adel_req got %b expected 1", req); else passed++;
      tick();
      idle();
      total++; if (epc_out !== 32'h3008) $display("[TB] FAIL adel_epc got %h expected %h", epc_out, 32'h3008); else passed++;
      rd(REG_CAUSE, v);
      total++; if (v !== 32'h0000_0010) $display("[TB] FAIL adel_cause got %h expected %h", v, 32'h10); else passed++;
      rd(REG_SR, v);
      total++; if (v !== 32'h0000_0002) $display("[TB] FAIL adel_exl got %h expected %h", v, 32'h2); else passed++;
      // leave the handler, then take AdES from a delay slot
      eret_m = 1'b1;
      tick();
      idle();
      rd(REG_SR, v);
      total++; if (v !== 32'h0) $display("[TB] FAIL eret_sr got %h expected %h", v, 32'h0); else passed++;
      exc_m = {1'b1, EXC_ADES}; pc_m = 32'h300c; bd_m = 1'b1;
      tick();
      idle();
      total++; if (epc_out !== 32'h3008) $display("[TB] FAIL ades_bd_epc got %h expected %h", epc_out, 32'h3008); else passed++;
      rd(REG_CAUSE, v);
      total++; if (v !== 32'h8000_0014) $display("[TB] FAIL ades_cause got %h expected %h", v, 32'h8000_0014); else passed++;
   endtask

   task automatic test_interrupt_priority();
      apply_reset();
      we = 1'b1; addr = REG_SR; wdata = 32'h0000_0401;
      tick();
      idle();
      rd(REG_SR, v);
      total++; if (v !== 32'h0000_0401) $display("[TB] FAIL sr_write got %h expected %h", v, 32'h401); else passed++;
      hwint = 6'b000001; exc_m = {1'b1, EXC_OV}; pc_m = 32'h2000;
      #1;
      total++; if (req !== 1'b1) $display("[TB] FAIL int_req got %b expected 1", req); else passed++;
      tick();
      rd(REG_CAUSE, v);
      total++; if (v !== 32'h0000_0400) $display("[TB] FAIL int_wins_cause got %h expected %h", v, 32'h400); else passed++;
      rd(REG_SR, v);
      total++; if (v !== 32'h0000_0403) $display("[TB] FAIL int_sr got %h expected %h", v, 32'h403); else passed++;
      // EXL now masks both the still-asserted interrupt and a new exception
      exc_m = {1'b1, EXC_RI};
      #1;
      total++; if (req !== 1'b0) $display("[TB] FAIL exl_masks_req got %b expected 0", req); else passed++;
      idle();
   endtask

   task automatic test_write_vs_req();
      apply_reset();
      exc_m = {1'b1, EXC_RI}; pc_m = 32'h5000;
      we = 1'b1; addr = REG_EPC; wdata = 32'h4000;
      #1;
      total++; if (req !== 1'b1) $display("[TB] FAIL wr_req got %b expected 1", req); else passed++;
      tick();
      idle();
      total++; if (epc_out !== 32'h5000) $display("[TB] FAIL req_beats_write got %h expected %h", epc_out, 32'h5000); else passed++;
      eret_m = 1'b1;
      tick();
      idle();
      rd(REG_SR, v);
      total++; if (v !== 32'h0) $display("[TB] FAIL eret_clears_exl got %h expected %h", v, 32'h0); else passed++;
      // plain writes: EPC sticks, Cause and PRId are read-only
      we = 1'b1; addr = REG_EPC; wdata = 32'h4000;
      tick();
      addr = REG_CAUSE; wdata = 32'hFFFF_FFFF;
      tick();
      addr = REG_PRID;
      tick();
      idle();
      total++; if (epc_out !== 32'h4000) $display("[TB] FAIL epc_write got %h expected %h", epc_out, 32'h4000); else passed++;
      rd(REG_CAUSE, v);
      total++; if (v !== 32'h0000_0028) $display("[TB] FAIL cause_readonly got %h expected %h", v, 32'h28); else passed++;
      rd(REG_PRID, v);
      total++; if (v !== 32'h4255_4141) $display("[TB] FAIL prid_readonly got %h expected %h", v, 32'h4255_4141); else passed++;
   endtask

`ifdef CP0_TIMER_EN
   task automatic test_timer();
      bit seen;
      apply_reset();
      seen = 1'b0;
      we = 1'b1; addr = REG_SR; wdata = 32'h0000_8001;
      tick();
      addr = REG_COMPARE; wdata = 32'd5;
      tick();
      addr = REG_COUNT; wdata = 32'd0;
      tick();
      idle();
      addr = REG_COUNT;
      for (int i = 0; i < 20; i++) begin
         if (req === 1'b1) begin
            seen = 1'b1;
            break;
         end
         tick();
      end
      total++; if (!seen) $display("[TB] FAIL timer_req got no req expected req within 20 cycles"); else passed++;
      total++; if (rdata !== 32'd5) $display("[TB] FAIL timer_count_at_req got %h expected %h", rdata, 32'd5); else passed++;
      tick();
      rd(REG_CAUSE, v);
      total++; if (v !== 32'h0000_8000) $display("[TB] FAIL timer_cause got %h expected %h", v, 32'h8000); else passed++;
      we = 1'b1; addr = REG_COMPARE; wdata = 32'd0;
      tick();
      idle();
      tick();
      rd(REG_CAUSE, v);
      total++; if (v !== 32'h0) $display("[TB] FAIL compare_write_clears got %h expected %h", v, 32'h0); else passed++;
      we = 1'b1; addr = REG_COUNT; wdata = 32'hFFFF_FFFF;
      tick();
      idle();
      rd(REG_COUNT, v);
      total++; if (v !== 32'hFFFF_FFFF) $display("[TB] FAIL count_write got %h expected %h", v, 32'hFFFF_FFFF); else passed++;
      tick();
      rd(REG_COUNT, v);
      total++; if (v !== 32'h0) $display("[TB] FAIL count_wrap got %h expected %h", v, 32'h0); else passed++;
   endtask
`else
   task automatic test_timer();
      apply_reset();
      we = 1'b1; addr = REG_COUNT; wdata = 32'h1234;
      tick();
      addr = REG_COMPARE; wdata = 32'h1;
      tick();
      idle();
      rd(REG_COUNT, v);
      total++; if (v !== 32'h0) $display("[TB] FAIL no_timer_count got %h expected %h", v, 32'h0); else passed++;
      rd(REG_COMPARE, v);
      total++; if (v !== 32'h0) $display("[TB] FAIL no_timer_compare got %h expected %h", v, 32'h0); else passed++;
   endtask
`endif

   task automatic test_reset_mid_handler();
      apply_reset();
      exc_m = {1'b1, EXC_ADES}; pc_m = 32'h7004; bd_m = 1'b1;
      tick();
      total++; if (epc_out !== 32'h7000) $display("[TB] FAIL pre_reset_epc got %h expected %h", epc_out, 32'h7000); else passed++;
      // exc_m stays valid; reset lands between edges
      #2;
      reset = 1'b1;
      rd(REG_SR, v);
      total++; if (v !== 32'h0) $display("[TB] FAIL async_reset_sr got %h expected %h", v, 32'h0); else passed++;
      rd(REG_CAUSE, v);
      total++; if (v !== 32'h0) $display("[TB] FAIL async_reset_cause got %h expected %h", v, 32'h0); else passed++;
      total++; if (epc_out !== 32'h0) $display("[TB] FAIL async_reset_epc got %h expected %h", epc_out, 32'h0); else passed++;
      total++; if (req !== 1'b0) $display("[TB] FAIL reset_blocks_req got %b expected 0", req); else passed++;
      @(posedge clk);
      #1;
      idle();
      reset = 1'b0;
      tick();
      rd(REG_SR, v);
      total++; if (v !== 32'h0) $display("[TB] FAIL post_reset_sr got %h expected %h", v, 32'h0); else passed++;
   endtask

   initial begin
      test_reset();
      test_exception();
      test_interrupt_priority();
      test_write_vs_req();
      test_timer();
      test_reset_mid_handler();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   // Safety net against a stuck run
   initial begin
      #200000;
      $display("[TB] FAIL watchdog got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
